// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that feeds one serial_tx transmitter.
// serial_tx has no busy flag, so this block times every frame itself and
// refuses new grants until the transmitter is guaranteed idle again.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DIVISOR = 868,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       trigger_out,
    output logic [7:0]                 val_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
    output logic                       busy_out,
    output logic [CNT_W-1:0]           frames_sent_out
);

    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int HOLD_CYC  = DIVISOR + 1;
    localparam int FRAME_CYC = 12 * (DIVISOR + 1);
    localparam int TIMER_W   = $clog2(FRAME_CYC + 1);

    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] FRAME_LAST = TIMER_W'(FRAME_CYC - 1);
    localparam logic [ID_W:0]      NUM_REQ_W  = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_found;
    logic [ID_W:0]        cand;
    logic [ID_W:0]        ptr_after;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 accept;
    logic                 lock_done;

    // Find the first valid requester at or after the round-robin pointer.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!pick_found && req_valid_in[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Turn the chosen index into a one-hot grant, offered only while idle.
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_onehot[i] = pick_found && (pick_idx == ID_W'(i));
        end
        req_ready_out = (state == S_IDLE && !rst_in) ? pick_onehot : '0;
        accept        = |(req_ready_out & req_valid_in);
        ptr_after     = {1'b0, pick_idx} + (ID_W+1)'(1);
        if (ptr_after == NUM_REQ_W) begin
            ptr_after = '0;
        end
    end

    // Next-state logic: hold trigger for one bit period, then wait out the frame.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        trigger_out = 1'b0;
        lock_done   = 1'b0;
        case (state)
            S_IDLE: begin
                timer_next = '0;
                if (accept) begin
                    state_next = S_TRIG;
                end
            end
            S_TRIG: begin
                trigger_out = 1'b1;
                timer_next  = timer + TIMER_W'(1);
                if (timer == HOLD_LAST) begin
                    state_next = S_LOCK;
                end
            end
            S_LOCK: begin
                if (timer == FRAME_LAST) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                    lock_done  = 1'b1;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // State and frame timer registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Capture the accepted byte and bookkeeping; val_out stays put until idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            val_out         <= '0;
            grant_id_out    <= '0;
            busy_out        <= 1'b0;
            frames_sent_out <= '0;
            rr_ptr          <= '0;
        end else if (accept) begin
            val_out         <= req_data_in[8*pick_idx +: 8];
            grant_id_out    <= pick_idx;
            busy_out        <= 1'b1;
            frames_sent_out <= frames_sent_out + CNT_W'(1);
            rr_ptr          <= ptr_after[ID_W-1:0];
        end else if (lock_done) begin
            busy_out        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a cycle-arithmetic reference model.
// A second instance with a 4-bit frame counter exercises counter wrap.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DIVISOR   = 4;
    localparam int HOLD_CYC  = DIVISOR + 1;
    localparam int FRAME_CYC = 12 * (DIVISOR + 1);

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NUM_REQ-1:0]   req_valid_in;
    logic [8*NUM_REQ-1:0] req_data_in;

    logic [NUM_REQ-1:0]   ready_a, ready_b;
    logic                 trig_a, trig_b;
    logic [7:0]           val_a, val_b;
    logic [1:0]           gid_a, gid_b;
    logic                 busy_a, busy_b;
    logic [15:0]          frames_a;
    logic [3:0]           frames_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit                 acc_ok;
    int                 acc_cyc;
    int                 rr;
    int                 frames;
    logic [7:0]         m_val;
    int                 m_gid;
    logic [NUM_REQ-1:0] prev_ready;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DIVISOR(DIVISOR), .CNT_W(16)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in),
        .req_ready_out(ready_a), .trigger_out(trig_a), .val_out(val_a),
        .grant_id_out(gid_a), .busy_out(busy_a), .frames_sent_out(frames_a)
    );

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DIVISOR(DIVISOR), .CNT_W(4)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in),
        .req_ready_out(ready_b), .trigger_out(trig_b), .val_out(val_b),
        .grant_id_out(gid_b), .busy_out(busy_b), .frames_sent_out(frames_b)
    );

    always #5 clk_in = ~clk_in;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Return the model state to its post-reset values.
    task automatic modelReset();
        acc_ok = 1'b0;
        acc_cyc = 0;
        rr = 0;
        frames = 0;
        m_val = 8'h00;
        m_gid = 0;
    endtask

    // Expected grant: first valid requester from rr, only once the frame window has elapsed.
    function automatic logic [NUM_REQ-1:0] modelReady(input logic rst, input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        bit found;
        int idx;
        r = '0;
        found = 1'b0;
        if (!rst && (!acc_ok || (cyc - acc_cyc) >= FRAME_CYC + 1)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr + k) % NUM_REQ;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    r[idx] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Drive one cycle of inputs for the requested scenario.
    task automatic applyStimulus(input int mode);
        rst_in = 1'b0;
        case (mode)
            0: begin
                rst_in = 1'b1;
                req_valid_in = '0;
            end
            1: begin
                req_valid_in = 4'b0100;
                req_data_in[23:16] = 8'hA5;
            end
            2: begin
                req_valid_in = 4'b1111;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (prev_ready[i]) req_data_in[8*i +: 8] = 8'($urandom);
                end
            end
            3: begin
                req_valid_in = 4'b0010;
                if (prev_ready[1]) req_data_in[15:8] = 8'($urandom);
            end
            4: begin
                rst_in = ($urandom_range(0, 249) == 0);
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_valid_in[i] = ($urandom_range(0, 9) < 6);
                    if ($urandom_range(0, 3) == 0) req_data_in[8*i +: 8] = 8'($urandom);
                end
            end
            default: begin
                req_valid_in = '0;
            end
        endcase
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
    task automatic step(input int mode);
        int d;
        logic [NUM_REQ-1:0] er;
        @(negedge clk_in);
        cyc++;
        d = acc_ok ? (cyc - acc_cyc) : 100000;
        checkOutput("trigger", 32'(trig_a), 32'(d >= 1 && d <= HOLD_CYC));
        checkOutput("busy", 32'(busy_a), 32'(d >= 1 && d <= FRAME_CYC));
        checkOutput("val", 32'(val_a), 32'(m_val));
        checkOutput("grant_id", 32'(gid_a), 32'(m_gid));
        checkOutput("frames16", 32'(frames_a), 32'(frames % 65536));
        checkOutput("frames4", 32'(frames_b), 32'(frames % 16));
        checkOutput("trigger_w4", 32'(trig_b), 32'(d >= 1 && d <= HOLD_CYC));
        applyStimulus(mode);
        #1;
        er = modelReady(rst_in, req_valid_in);
        checkOutput("ready", 32'(ready_a), 32'(er));
        checkOutput("ready_w4", 32'(ready_b), 32'(er));
        if (rst_in) begin
            modelReset();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (er[i]) begin
                    m_val = req_data_in[8*i +: 8];
                    m_gid = i;
                    frames++;
                    rr = (i + 1) % NUM_REQ;
                    acc_cyc = cyc;
                    acc_ok = 1'b1;
                end
            end
        end
        prev_ready = er;
    endtask

    task automatic runPhase(input int mode, input int cycles);
        for (int n = 0; n < cycles; n++) step(mode);
    endtask

    initial begin
        rst_in = 1'b1;
        req_valid_in = '0;
        req_data_in = {$urandom};
        prev_ready = '0;
        modelReset();
        @(negedge clk_in);
        @(negedge clk_in);
        runPhase(1, 70);
        runPhase(5, 5);
        runPhase(2, 320);
        runPhase(3, 130);
        runPhase(0, 2);
        runPhase(3, 100);
        runPhase(0, 2);
        runPhase(2, 17 * (FRAME_CYC + 1) + 5);
        runPhase(4, 2500);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
